traffic_ctrl_param: RTL and testbench
=====================================

# traffic_ctrl_param

Parametrised two-road traffic-light controller with a built-in one-second prescaler, a pedestrian request latch, a flashing-yellow night mode and a two-digit seven-segment countdown. It sequences road A and road B through green/yellow/all-red phases of configurable length. It counts down the remaining seconds of each phase and drives both LED groups, a walk lamp and two display digits directly. It replaces the single-road light/counter/divider/seven-seg cluster at system level.

## Interface
- TICK_DIV, 50000000: clk cycles per one-second tick (≥2)
- GREEN_T, 5: green duration in seconds, per road (1..99)
- YELLOW_T, 2: yellow duration in seconds (1..99)
- ALLRED_T, 1: all-red clearance in seconds (1..99)
- PED_MIN, 2: remaining road-A green after a pedestrian request is honoured (1..GREEN_T)
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- night  in  1  level; 1 selects flashing-yellow mode
- ped_req  in  1  pedestrian button, level-sampled every clk
- ledA  out  3  road A lamps {R,Y,G}, 1 = lit
- ledB  out  3  road B lamps {R,Y,G}, 1 = lit
- ped_walk  out  1  walk lamp for crossing road A
- count  out  7  remaining seconds of the current phase (binary)
- ssTens  out  7  tens digit of count, {g,f,e,d,c,b,a}, active-low
- ssOnes  out  7  ones digit of count, same encoding

## Operation
- Prescaler: free-running 0..TICK_DIV-1. `tick` is a one-cycle pulse when prescaler = TICK_DIV-1. Cleared only by rst; phase changes do not restart it.
- States: A_GRN → A_YEL → RED1 → B_GRN → B_YEL → RED2 → A_GRN, plus NIGHT.
- Lamps: A_GRN ledA=001, ledB=100; A_YEL ledA=010, ledB=100; RED1/RED2 both 100; B_GRN ledA=100, ledB=001; B_YEL ledA=100, ledB=010; NIGHT both = {0,flash,0}.
- ped_walk = 1 only in B_GRN.
- On tick in a timed state:
  - count > 1: count decrements.
  - count = 1: advance to the next state and load its duration (GREEN_T / YELLOW_T / ALLRED_T).
- Pedestrian request:
  - ped_pend sets on any cycle with ped_req=1, except in B_GRN, where requests are ignored.
  - ped_pend clears on entry to B_GRN.
  - On tick in A_GRN with ped_pend=1 and count > PED_MIN: count loads PED_MIN instead of decrementing.
  - With count ≤ PED_MIN, normal decrement applies.
- Night mode:
  - night=1 in any timed state: next clk enters NIGHT, count=0, flash=1. The current phase is abandoned; ped_pend is retained.
  - In NIGHT, flash toggles on every tick.
  - night=0 in NIGHT: next clk enters RED2 with count=ALLRED_T, then the normal cycle continues.
- Priority in the same cycle: rst > night > tick-driven phase advance > pedestrian shortening.
- Display: tens = count/10, ones = count%10, each digit encoded for 0..9 (0 → 1000000, 5 → 0010010). Codes 10..15 never occur.
- Durations outside 1..99 are illegal; no runtime checking.

## Timing
- Reset values, on the clk after rst=1:
  - state A_GRN, count=GREEN_T, prescaler=0, ped_pend=0, flash=1
  - ledA=001, ledB=100, ped_walk=0
  - ss digits reflect GREEN_T
- state, count, prescaler, ped_pend and flash are registered. Lamps, walk and segments are combinational decodes of the registered state/count.
- All outputs therefore change on the clk edge that consumes tick.
- Phase length is exactly duration×TICK_DIV clocks, except the first phase after entering RED2 from NIGHT, which may be up to TICK_DIV-1 clocks short.
- Full normal cycle = 2×(GREEN_T+YELLOW_T+ALLRED_T)×TICK_DIV clocks.
- ped_req to shortening: honoured at the first tick after ped_pend is set; ped_pend is visible one clk after ped_req.
- night entry/exit latency: 1 clk, independent of tick.
- rst mid-phase: immediate return to reset values; any pending pedestrian request is discarded.

## Test plan
Bench parameters: TICK_DIV=4, GREEN_T=5, YELLOW_T=2, ALLRED_T=1, PED_MIN=2.
- Reset: rst high 2 clks → ledA=001, ledB=100, count=5, ssTens=1000000, ssOnes=0010010, ped_walk=0.
- Free run 64 clks → sequence A_GRN(20 clks), A_YEL(8), RED1(4), B_GRN(20, ped_walk=1), B_YEL(8), RED2(4); back to A_GRN with count=5 at clk 64.
- ped_req 1-clk pulse right after reset → A_GRN counts 5,2,1, then A_YEL. B_GRN lasts 20 clks with ped_walk=1; ped_pend=0 afterwards.
- ped_req pulse while A_GRN count=2 → normal 2,1 sequence. ped_req held throughout B_GRN → no effect, and the next A_GRN runs the full 5 s.
- night=1 during B_GRN count=3 → next clk ledA=ledB=010 and count=0, toggling to 000 every 4 clks. night=0 → next clk both 100 with count=1, then A_GRN count=5 after the next tick.
- rst pulse in A_YEL with ped_pend=1 → reset values restored. The following A_GRN runs 20 clks, with no shortening.

Source files
------------

// File: rtl/traffic_ctrl_param_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | traffic_ctrl_param_if                                                     |
// | Control inputs and lamp/display outputs of the two-road light controller. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface traffic_ctrl_param_if;
    logic       night;
    logic       ped_req;
    logic [2:0] ledA;
    logic [2:0] ledB;
    logic       ped_walk;
    logic [6:0] count;
    logic [6:0] ssTens;
    logic [6:0] ssOnes;

    modport master (
        output night, ped_req,
        input  ledA, ledB, ped_walk, count, ssTens, ssOnes
    );

    modport slave (
        input  night, ped_req,
        output ledA, ledB, ped_walk, count, ssTens, ssOnes
    );
endinterface
`default_nettype wire

// File: rtl/traffic_ctrl_param.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | traffic_ctrl_param                                                        |
// | Two-road light sequencer with prescaler, ped latch, night flash, 7-seg.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module traffic_ctrl_param #(
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int PED_MIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    traffic_ctrl_param_if.slave   bus
);

    localparam int         c_pw        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(TICK_DIV - 1);
    localparam logic [6:0] c_green     = 7'(GREEN_T);
    localparam logic [6:0] c_yellow    = 7'(YELLOW_T);
    localparam logic [6:0] c_allred    = 7'(ALLRED_T);
    localparam logic [6:0] c_ped_min   = 7'(PED_MIN);
    localparam logic [2:0] c_lamp_r    = 3'b100;
    localparam logic [2:0] c_lamp_y    = 3'b010;
    localparam logic [2:0] c_lamp_g    = 3'b001;

    typedef enum logic [2:0] {
        ST_A_GRN = 3'd0,
        ST_A_YEL = 3'd1,
        ST_RED1  = 3'd2,
        ST_B_GRN = 3'd3,
        ST_B_YEL = 3'd4,
        ST_RED2  = 3'd5,
        ST_NIGHT = 3'd6
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_pw-1:0] r_presc;
    logic [6:0]      r_count, w_count_nxt;
    logic            r_ped_pend, w_ped_nxt;
    logic            r_flash, w_flash_nxt;
    logic            w_tick;
    logic [3:0]      w_tens, w_ones;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign w_tick = (r_presc == c_presc_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_A_GRN;
            r_presc    <= '0;
            r_count    <= c_green;
            r_ped_pend <= 1'b0;
            r_flash    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_tick ? '0 : r_presc + 1'b1;
            r_count    <= w_count_nxt;
            r_ped_pend <= w_ped_nxt;
            r_flash    <= w_flash_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flash_nxt = r_flash;
        w_ped_nxt   = r_ped_pend;

        if (r_state != ST_NIGHT && bus.night) begin
            w_state_nxt = ST_NIGHT;
            w_count_nxt = '0;
            w_flash_nxt = 1'b1;
        end else if (r_state == ST_NIGHT) begin
            if (!bus.night) begin
                w_state_nxt = ST_RED2;
                w_count_nxt = c_allred;
            end else if (w_tick) begin
                w_flash_nxt = ~r_flash;
            end
        end else if (w_tick) begin
            if (r_count > 7'd1) begin
                // A pending walk request cuts the remaining A green short.
                if (r_state == ST_A_GRN && r_ped_pend && r_count > c_ped_min)
                    w_count_nxt = c_ped_min;
                else
                    w_count_nxt = r_count - 7'd1;
            end else begin
                case (r_state)
                    ST_A_GRN: begin w_state_nxt = ST_A_YEL; w_count_nxt = c_yellow; end
                    ST_A_YEL: begin w_state_nxt = ST_RED1;  w_count_nxt = c_allred; end
                    ST_RED1:  begin w_state_nxt = ST_B_GRN; w_count_nxt = c_green;  end
                    ST_B_GRN: begin w_state_nxt = ST_B_YEL; w_count_nxt = c_yellow; end
                    ST_B_YEL: begin w_state_nxt = ST_RED2;  w_count_nxt = c_allred; end
                    ST_RED2:  begin w_state_nxt = ST_A_GRN; w_count_nxt = c_green;  end
                    default:  begin w_state_nxt = r_state;  w_count_nxt = r_count;  end
                endcase
            end
        end

        // Entering the walk phase serves the request, so clearing wins.
        if (w_state_nxt == ST_B_GRN && r_state != ST_B_GRN)
            w_ped_nxt = 1'b0;
        else if (bus.ped_req && r_state != ST_B_GRN)
            w_ped_nxt = 1'b1;
    end

    always_comb begin
        bus.ledA = c_lamp_r;
        bus.ledB = c_lamp_r;
        case (r_state)
            ST_A_GRN: bus.ledA = c_lamp_g;
            ST_A_YEL: bus.ledA = c_lamp_y;
            ST_B_GRN: bus.ledB = c_lamp_g;
            ST_B_YEL: bus.ledB = c_lamp_y;
            ST_NIGHT: begin
                bus.ledA = {1'b0, r_flash, 1'b0};
                bus.ledB = {1'b0, r_flash, 1'b0};
            end
            default: ;
        endcase
    end

    assign w_tens       = 4'(r_count / 7'd10);
    assign w_ones       = 4'(r_count % 7'd10);
    assign bus.ped_walk = (r_state == ST_B_GRN);
    assign bus.count    = r_count;
    assign bus.ssTens   = seg7(w_tens);
    assign bus.ssOnes   = seg7(w_ones);

endmodule
`default_nettype wire

// File: tb/tb_traffic_ctrl_param.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_traffic_ctrl_param                                                     |
// | Directed bench with a phase-table reference model and per-cycle compare.  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_traffic_ctrl_param;

    localparam int c_tick_div = 4;
    localparam int c_green    = 5;
    localparam int c_yellow   = 2;
    localparam int c_allred   = 1;
    localparam int c_ped_min  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   t      = 0;

    traffic_ctrl_param_if bus ();

    traffic_ctrl_param #(
        .TICK_DIV (c_tick_div),
        .GREEN_T  (c_green),
        .YELLOW_T (c_yellow),
        .ALLRED_T (c_allred),
        .PED_MIN  (c_ped_min)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Phase index 0..5 walks A_GRN..RED2 in order; 6 is the night flash.
    int         dur    [6] = '{c_green, c_yellow, c_allred, c_green, c_yellow, c_allred};
    logic [2:0] lamp_a [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] lamp_b [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [6:0] seg_tbl[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int m_phase = 0;
    int m_cnt   = 0;
    int m_div   = 0;
    bit m_ped   = 1'b0;
    bit m_flash = 1'b1;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit tk;
        bit ped_n;
        int prev;
        if (rst) begin
            m_phase = 0;
            m_cnt   = c_green;
            m_div   = 0;
            m_ped   = 1'b0;
            m_flash = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            tk    = (m_div == c_tick_div - 1);
            m_div = (m_div + 1) % c_tick_div;
            prev  = m_phase;
            ped_n = m_ped | (bus.ped_req && prev != 3);
            if (prev != 6 && bus.night) begin
                m_phase = 6;
                m_cnt   = 0;
                m_flash = 1'b1;
            end else if (prev == 6) begin
                if (!bus.night) begin
                    m_phase = 5;
                    m_cnt   = c_allred;
                end else if (tk) begin
                    m_flash = !m_flash;
                end
            end else if (tk) begin
                if (m_cnt > 1)
                    m_cnt = (prev == 0 && m_ped && m_cnt > c_ped_min) ? c_ped_min : m_cnt - 1;
                else begin
                    m_phase = (prev + 1) % 6;
                    m_cnt   = dur[m_phase];
                end
            end
            if (m_phase == 3 && prev != 3)
                ped_n = 1'b0;
            m_ped = ped_n;
        end
    end

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %b expected %b", name, t, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [2:0] ea, eb;
        if (m_valid) begin
            ea = (m_phase == 6) ? {1'b0, m_flash, 1'b0} : lamp_a[m_phase];
            eb = (m_phase == 6) ? {1'b0, m_flash, 1'b0} : lamp_b[m_phase];
            chk("model_ledA",   7'(bus.ledA),     7'(ea));
            chk("model_ledB",   7'(bus.ledB),     7'(eb));
            chk("model_walk",   7'(bus.ped_walk), 7'(m_phase == 3));
            chk("model_count",  bus.count,        7'(m_cnt));
            chk("model_ssTens", bus.ssTens,       seg_tbl[m_cnt / 10]);
            chk("model_ssOnes", bus.ssOnes,       seg_tbl[m_cnt % 10]);
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        t   = 0;
    endtask

    task automatic step_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.night   = 1'b0;
        bus.ped_req = 1'b0;
        @(negedge clk);

        // Reset values and free-running cycle
        do_reset(2);
        chk("rst_ledA",   7'(bus.ledA),     7'b0000001);
        chk("rst_ledB",   7'(bus.ledB),     7'b0000100);
        chk("rst_count",  bus.count,        7'd5);
        chk("rst_ssTens", bus.ssTens,       7'b1000000);
        chk("rst_ssOnes", bus.ssOnes,       7'b0010010);
        chk("rst_walk",   7'(bus.ped_walk), 7'd0);
        step_to(19); chk("run_a_grn_end", 7'(bus.ledA), 7'b0000001);
        step_to(20); chk("run_a_yel",     7'(bus.ledA), 7'b0000010);
        step_to(32); chk("run_b_grn",     7'(bus.ledB), 7'b0000001);
        chk("run_walk", 7'(bus.ped_walk), 7'd1);
        step_to(64); chk("run_wrap_count", bus.count, 7'd5);
        chk("run_wrap_ledA", 7'(bus.ledA), 7'b0000001);

        // Pedestrian request right after reset shortens A green to 5,2,1
        do_reset(2);
        bus.ped_req = 1'b1; step_to(1); bus.ped_req = 1'b0;
        step_to(4);  chk("ped_count2", bus.count, 7'd2);
        step_to(8);  chk("ped_count1", bus.count, 7'd1);
        step_to(12); chk("ped_a_yel",  7'(bus.ledA), 7'b0000010);
        step_to(24); chk("ped_walk_on", 7'(bus.ped_walk), 7'd1);
        step_to(43); chk("ped_walk_last", 7'(bus.ped_walk), 7'd1);
        step_to(44); chk("ped_walk_off", 7'(bus.ped_walk), 7'd0);
        step_to(75); chk("ped_full_green", 7'(bus.ledA), 7'b0000001);
        step_to(76); chk("ped_next_yel",   7'(bus.ledA), 7'b0000010);

        // Request at count=2 has no effect; request held through B green ignored
        do_reset(2);
        step_to(12); chk("late_count2", bus.count, 7'd2);
        bus.ped_req = 1'b1; step_to(13); bus.ped_req = 1'b0;
        step_to(16); chk("late_count1", bus.count, 7'd1);
        step_to(20); chk("late_a_yel",  7'(bus.ledA), 7'b0000010);
        step_to(32); chk("hold_b_grn",  7'(bus.ped_walk), 7'd1);
        bus.ped_req = 1'b1; step_to(52); bus.ped_req = 1'b0;
        step_to(64); chk("hold_a_grn_count", bus.count, 7'd5);
        step_to(83); chk("hold_full_green", 7'(bus.ledA), 7'b0000001);
        step_to(84); chk("hold_next_yel",   7'(bus.ledA), 7'b0000010);

        // Night mode entered from B green, then released
        do_reset(2);
        step_to(40); chk("night_pre_count", bus.count, 7'd3);
        bus.night = 1'b1;
        step_to(41); chk("night_ledA", 7'(bus.ledA), 7'b0000010);
        chk("night_ledB",  7'(bus.ledB), 7'b0000010);
        chk("night_count", bus.count,    7'd0);
        step_to(43); chk("night_hold_on", 7'(bus.ledA), 7'b0000010);
        step_to(44); chk("night_flash_off", 7'(bus.ledA), 7'b0000000);
        step_to(48); chk("night_flash_on",  7'(bus.ledA), 7'b0000010);
        step_to(50); bus.night = 1'b0;
        step_to(51); chk("exit_ledA", 7'(bus.ledA), 7'b0000100);
        chk("exit_ledB",  7'(bus.ledB), 7'b0000100);
        chk("exit_count", bus.count,    7'd1);
        step_to(52); chk("exit_a_grn", 7'(bus.ledA), 7'b0000001);
        chk("exit_count5", bus.count, 7'd5);

        // Reset in A yellow with a pending request discards it
        do_reset(2);
        bus.ped_req = 1'b1; step_to(1); bus.ped_req = 1'b0;
        step_to(13); chk("mid_a_yel", 7'(bus.ledA), 7'b0000010);
        step_to(14);
        do_reset(1);
        chk("mid_rst_count", bus.count, 7'd5);
        chk("mid_rst_ledA",  7'(bus.ledA), 7'b0000001);
        step_to(4);  chk("mid_no_shorten", bus.count, 7'd4);
        step_to(19); chk("mid_green_end",  7'(bus.ledA), 7'b0000001);
        step_to(20); chk("mid_a_yel_next", 7'(bus.ledA), 7'b0000010);

        step_to(22);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
